// File: rtl/counter_seq_pkg.sv
// Shared types for the stop-counter run sequencer: FSM state encoding and
// the default width of the measured cycle count.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int CYC_W_DEFAULT = 32;

endpackage

// File: rtl/counter_seq_fifo.sv
// Request FIFO for the counter sequencer. o_ready is a registered not-full
// flag (low during reset); pushes are gated by it, pops by not-empty.
module counter_seq_fifo #(
  parameter int DEPTH      = 4,
  parameter int STOP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [STOP_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [STOP_WIDTH-1:0] o_pop_data,
  output logic                  o_ready,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_ready;
  logic [STOP_WIDTH-1:0] r_mem [DEPTH];

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full_nxt;
  logic [AW:0] w_wr_nxt;
  logic [AW:0] w_rd_nxt;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push   = i_push && r_ready;
  assign w_pop    = i_pop && !w_empty;
  assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // Ready is computed from the post-edge pointers so a same-cycle pop never bypasses it.
  assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_ready  <= !w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_ready    = r_ready;
  assign o_empty    = w_empty;

endmodule

// File: rtl/counter_sequencer.sv
// Run controller in front of the free-running stop counter: queues stop values,
// runs the counter once per value and reports the measured run length.
// Optional watchdog enabled by defining COUNTER_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | counter held in reset, waiting for a queued stop value
// CLEAR  | one cycle: counter still held, new stop presented, cycle count cleared
// RUN    | counter released, counting cycles until done (or watchdog)
// REPORT | counter held, response valid until rsp_ready
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int          STOP_WIDTH = 8,
  parameter int          DEPTH      = 4,
  parameter int          CYC_W      = CYC_W_DEFAULT,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [STOP_WIDTH-1:0] req_stop,
  output logic                  req_ready,
  output logic                  cnt_reset_l,
  output logic [STOP_WIDTH-1:0] cnt_stop,
  input  logic                  cnt_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [STOP_WIDTH-1:0] rsp_stop,
  output logic [CYC_W-1:0]      rsp_cycles,
  output logic                  rsp_timeout,
  output logic                  busy
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [STOP_WIDTH-1:0] r_stop_q;
  logic [CYC_W-1:0]      r_cyc;
  logic [STOP_WIDTH-1:0] r_rsp_stop;
  logic [CYC_W-1:0]      r_rsp_cycles;
  logic                  r_rsp_timeout;

  logic                  w_fifo_empty;
  logic [STOP_WIDTH-1:0] w_fifo_data;
  logic                  w_pop;
  logic                  w_timeout;

  counter_seq_fifo #(
    .DEPTH      (DEPTH),
    .STOP_WIDTH (STOP_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (req_valid),
    .i_push_data (req_stop),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_ready     (req_ready),
    .o_empty     (w_fifo_empty)
  );

  assign w_pop = (r_state == IDLE) && !w_fifo_empty;

`ifdef COUNTER_SEQ_TIMEOUT_EN
  assign w_timeout = (r_cyc == CYC_W'(TIMEOUT)) && !cnt_done;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty) w_state_nxt = CLEAR;
      CLEAR:   w_state_nxt = RUN;
      RUN:     if (cnt_done || w_timeout) w_state_nxt = REPORT;
      REPORT:  if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // done has priority over the watchdog; the cycle count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stop_q      <= '0;
      r_cyc         <= '0;
      r_rsp_stop    <= '0;
      r_rsp_cycles  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) r_stop_q <= w_fifo_data;
        end
        CLEAR: begin
          r_cyc <= '0;
        end
        RUN: begin
          if (cnt_done) begin
            r_rsp_stop    <= r_stop_q;
            r_rsp_cycles  <= r_cyc;
            r_rsp_timeout <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_stop    <= r_stop_q;
            r_rsp_cycles  <= r_cyc;
            r_rsp_timeout <= 1'b1;
          end else if (r_cyc != '1) begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt_reset_l = (r_state == RUN);
  assign cnt_stop    = r_stop_q;
  assign rsp_valid   = (r_state == REPORT);
  assign rsp_stop    = r_rsp_stop;
  assign rsp_cycles  = r_rsp_cycles;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = !w_fifo_empty || (r_state != IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and scoreboarded checks of counter_sequencer driving a behavioural
// stop counter; watchdog cases are built when COUNTER_SEQ_TIMEOUT_EN is defined.
module tb_counter_sequencer;

  localparam int SW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 32;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [SW-1:0] req_stop;
  logic          req_ready;
  logic          cnt_reset_l;
  logic [SW-1:0] cnt_stop;
  logic          cnt_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [SW-1:0] rsp_stop;
  logic [CW-1:0] rsp_cycles;
  logic          rsp_timeout;
  logic          busy;

  logic [SW-1:0] r_ctr;
  logic          stub_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  counter_sequencer #(
    .STOP_WIDTH (SW),
    .DEPTH      (DEPTH),
    .CYC_W      (CW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_stop    (req_stop),
    .req_ready   (req_ready),
    .cnt_reset_l (cnt_reset_l),
    .cnt_stop    (cnt_stop),
    .cnt_done    (cnt_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_stop    (rsp_stop),
    .rsp_cycles  (rsp_cycles),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  // Behavioural free-running stop counter.
  always @(posedge clk) begin
    if (!cnt_reset_l) r_ctr <= '0;
    else              r_ctr <= r_ctr + 8'd1;
  end
  assign cnt_done = stub_zero ? 1'b0 : (r_ctr == cnt_stop);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sets up a push for the coming edge; successive calls push back-to-back.
  task automatic push_one(input logic [SW-1:0] s);
    @(negedge clk);
    req_valid = 1'b1;
    req_stop  = s;
  endtask

  // Completes the last push edge and drops req_valid; returns at a negedge.
  task automatic push_end();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits at negedges for rsp_valid; counts edges and cycles with cnt_reset_l high.
  task automatic wait_rsp(output int edges, output int hi);
    edges = 0;
    hi    = 0;
    while (!rsp_valid && edges < 1000) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (cnt_reset_l) hi++;
    end
    if (!rsp_valid) check_eq("rsp_wait", rsp_valid, 1);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("valid_after_ack", rsp_valid, 0);
  endtask

  task automatic run_one(input logic [SW-1:0] s, input logic [CW-1:0] exp_cyc,
                         input logic exp_tmo);
    int e, h;
    push_one(s);
    push_end();
    wait_rsp(e, h);
    check_eq("run_stop", rsp_stop, s);
    check_eq("run_cycles", rsp_cycles, exp_cyc);
    check_eq("run_timeout", rsp_timeout, exp_tmo);
    ack();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, h;
    logic [SW-1:0] hs;
    logic [CW-1:0] hc;
    logic ht;
    bit stable;
    bit seen;
    logic [SW-1:0] exp_q [$];
    logic [SW-1:0] exp_stop;
    logic [SW-1:0] seq [4];
    logic [SW-1:0] exp_s;

    reset = 1'b1; req_valid = 1'b0; req_stop = '0; rsp_ready = 1'b0; stub_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_cnt_reset_l", cnt_reset_l, 0);
    check_eq("rst_cnt_stop", cnt_stop, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_stop", rsp_stop, 0);
    check_eq("rst_rsp_cycles", rsp_cycles, 0);
    check_eq("rst_rsp_timeout", rsp_timeout, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("req_ready_after_rst", req_ready, 1);

    // Single run, stop 5: response after edge e8.
    push_one(8'd5);
    push_end();
    wait_rsp(e, h);
    check_eq("s5_latency", e, 8);
    check_eq("s5_stop", rsp_stop, 5);
    check_eq("s5_cycles", rsp_cycles, 5);
    check_eq("s5_timeout", rsp_timeout, 0);
    check_eq("s5_run_len", h, 6);
    ack();
    repeat (10) @(negedge clk);
    check_eq("s5_single_rsp", rsp_valid, 0);
    check_eq("s5_idle", busy, 0);

    // Stop 0: done in the first RUN cycle.
    push_one(8'd0);
    push_end();
    wait_rsp(e, h);
    check_eq("s0_latency", e, 3);
    check_eq("s0_cycles", rsp_cycles, 0);
    check_eq("s0_reset_l_high", h, 1);
    check_eq("s0_report_reset_l", cnt_reset_l, 0);
    ack();

    // Fill the FIFO while a response is pending, then drain in order.
    push_one(8'd9);
    push_end();
    wait_rsp(e, h);
    check_eq("fill_ready_before", req_ready, 1);
    push_one(8'd3);
    push_one(8'd1);
    push_one(8'd7);
    push_one(8'd2);
    @(posedge clk);
    @(negedge clk);
    check_eq("fill_ready_full", req_ready, 0);
    req_stop = 8'd99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("fill_ready_still_full", req_ready, 0);
    check_eq("fill_busy", busy, 1);
    check_eq("fill_head_stop", rsp_stop, 9);
    check_eq("fill_head_cycles", rsp_cycles, 9);
    ack();
    seq[0] = 8'd3; seq[1] = 8'd1; seq[2] = 8'd7; seq[3] = 8'd2;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(e, h);
      check_eq("order_stop", rsp_stop, seq[i]);
      check_eq("order_cycles", rsp_cycles, seq[i]);
      check_eq("order_timeout", rsp_timeout, 0);
      if (i == 1) begin
        hs = rsp_stop; hc = rsp_cycles; ht = rsp_timeout;
        stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (!rsp_valid || rsp_stop !== hs || rsp_cycles !== hc || rsp_timeout !== ht)
            stable = 1'b0;
        end
        check_eq("hold_stable", stable, 1);
        check_eq("hold_cnt_reset_l", cnt_reset_l, 0);
      end
      ack();
    end
    repeat (20) @(negedge clk);
    check_eq("full_push_dropped", rsp_valid, 0);
    check_eq("fill_drained", busy, 0);

    // Reset in the middle of a long run with two entries queued.
    push_one(8'd200);
    push_one(8'd10);
    push_one(8'd11);
    push_end();
    repeat (10) @(negedge clk);
    check_eq("mid_running", cnt_reset_l, 1);
    check_eq("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_cnt_reset_l", cnt_reset_l, 0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_ready_low", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_ready_back", req_ready, 1);
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check_eq("mid_rst_discarded", seen, 0);

`ifdef COUNTER_SEQ_TIMEOUT_EN
    stub_zero = 1'b1;
    run_one(8'd50, 32'd16, 1'b1);
    stub_zero = 1'b0;
    run_one(8'd16, 32'd16, 1'b0);
    run_one(8'd17, 32'd16, 1'b1);
    run_one(8'd15, 32'd15, 1'b0);
`else
    run_one(8'd40, 32'd40, 1'b0);
`endif

    // Random traffic with rsp_ready tied high, scoreboarded.
    rsp_ready = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", rsp_valid, 0);
        end else begin
          exp_s = exp_q.pop_front();
          check_eq("sb_stop", rsp_stop, exp_s);
          check_eq("sb_cycles", rsp_cycles, exp_s);
          check_eq("sb_timeout", rsp_timeout, 0);
        end
      end
      req_valid = ($urandom_range(0, 3) == 0);
      req_stop  = 8'($urandom_range(0, 15));
      if (req_valid && req_ready) exp_q.push_back(req_stop);
    end
    req_valid = 1'b0;
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        exp_stop = exp_q.pop_front();
        check_eq("sb_drain_stop", rsp_stop, exp_stop);
        check_eq("sb_drain_cycles", rsp_cycles, exp_stop);
      end
    end
    check_eq("sb_all_reported", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check_eq("sb_final_idle", busy, 0);
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run controller that sits directly upstream of the free-running stop counter. Accepts a queue of stop values over a valid/ready request port, and for each one:
- holds the counter in reset, presents the stop value, then releases the counter;
- waits for the counter's `done`, measures elapsed run cycles and returns the result over a valid/ready response port.

Drives the counter's `reset_l` and `stop` inputs; consumes its `done` output.

## Interface
Parameters:
- `STOP_WIDTH`, 8, width of stop values; must match the counter's `STOP_WIDTH`
- `DEPTH`, 4, request FIFO entries; power of two, ≥2
- `CYC_W`, 32, width of measured cycle count
- `TIMEOUT`, 1024, watchdog limit in RUN cycles; used only with the macro

Ports (all synchronous to `clk`; one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `req_valid`  in  1  stop value offered
- `req_stop`  in  STOP_WIDTH  stop value
- `req_ready`  out  1  FIFO can accept
- `cnt_reset_l`  out  1  to counter `reset_l`; low holds counter at 0
- `cnt_stop`  out  STOP_WIDTH  to counter `stop`
- `cnt_done`  in  1  from counter `done` (combinational `ctr==stop` in counter)
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  result consumed
- `rsp_stop`  out  STOP_WIDTH  stop value of the completed run
- `rsp_cycles`  out  CYC_W  RUN cycles before `done` observed
- `rsp_timeout`  out  1  run ended by watchdog
- `busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Request push: `req_valid && req_ready`. `req_ready = !full`; it is registered state, with no same-cycle pop bypass. A pushed entry is visible to the FSM the next cycle.
- FSM states: IDLE, CLEAR, RUN, REPORT.
- IDLE:
  - `cnt_reset_l=0`.
  - If the FIFO is non-empty: pop the head into `stop_q`, go to CLEAR.
- CLEAR:
  - One cycle; `cnt_reset_l=0`, `cnt_stop=stop_q`, `cyc` cleared to 0.
  - Next state is RUN.
- RUN:
  - `cnt_reset_l=1`.
  - If `cnt_done`: latch `rsp_stop=stop_q`, `rsp_cycles=cyc`, `rsp_timeout=0`, go to REPORT.
  - Otherwise `cyc` increments, saturating at all-ones.
  - `cnt_done` is ignored in every state except RUN.
- REPORT:
  - `cnt_reset_l=0`, `rsp_valid=1`.
  - `rsp_*` are stable until `rsp_ready`; on the handshake go to IDLE.
- `cnt_stop` holds `stop_q` from CLEAR until the next pop.
- Correct counter: `rsp_cycles == rsp_stop`. Stop 0 gives `done` in the first RUN cycle, so cycles = 0.
- The FIFO may accept new requests in any state. A push to a full FIFO is not accepted and `req_stop` is not sampled.
- Pointer wrap: pointers are `$clog2(DEPTH)+1` bits; full/empty are derived from the MSB compare.

## Timing
- Reset values: `req_ready=0` while `reset` is high, 1 the cycle after. `cnt_reset_l=0`, `cnt_stop=0`, `rsp_valid=0`, `rsp_stop=0`, `rsp_cycles=0`, `rsp_timeout=0`, `busy=0`. FIFO is empty, FSM is IDLE.
- Latency with an empty FIFO and idle FSM, request pushed at edge e0:
  - pop and enter CLEAR at e1;
  - enter RUN at e2;
  - stop N: `done` is seen in the (N+1)th RUN cycle, and `rsp_valid` rises after edge e(3+N).
- Back-to-back runs: the REPORT handshake at edge e puts the FSM in IDLE at e; the next pop occurs at e+1.
- Reset mid-operation: takes effect on the next edge. It discards FIFO contents, the in-flight run and any pending response. `cnt_reset_l` goes low the cycle after.

## Configuration
- `COUNTER_SEQ_TIMEOUT_EN` defined:
  - in RUN, when `cyc == TIMEOUT` and `!cnt_done`, go to REPORT with `rsp_cycles=TIMEOUT`, `rsp_timeout=1`;
  - `done` and timeout in the same cycle: `done` wins, `rsp_timeout=0`.
- Undefined:
  - `rsp_timeout` is tied to 0 and RUN waits indefinitely;
  - `TIMEOUT` is unused and no comparator is built.

## Structure
- Package `counter_seq_pkg`: `state_e` enum (IDLE, CLEAR, RUN, REPORT) and the default `CYC_W` constant.
- Sub-module `counter_seq_fifo`: parameterised sync FIFO (`DEPTH`, `STOP_WIDTH`) with push/pop, full/empty, sync active-high reset.
- Top level: FSM, cycle counter, response registers, watchdog.

## Test plan
- Single run: push stop=5 with a real counter attached → exactly one response, `rsp_stop=5`, `rsp_cycles=5`, `rsp_timeout=0`, `rsp_valid` rises 8 edges after the push.
- Stop=0 → `rsp_cycles=0`; `cnt_reset_l` is high for exactly one cycle.
- Push 4 requests (3,1,7,2) back-to-back with DEPTH=4 → `req_ready` drops after the 4th. Responses come in order with cycles 3,1,7,2; hold `rsp_ready=0` for 10 cycles on the second response and check that `rsp_*` stay stable.
- Assert `reset` for one cycle during RUN of stop=200 with 2 queued entries → no response, `busy=0`, `cnt_reset_l=0`, `req_ready=1` the following cycle.
- With `COUNTER_SEQ_TIMEOUT_EN`, TIMEOUT=16, `cnt_done` stubbed to 0 → response `rsp_timeout=1`, `rsp_cycles=16`. Repeat with `done` forced exactly at `cyc=16` → `rsp_timeout=0`.
- `rsp_ready` tied high and random `req_valid` for 2000 cycles with random stops → scoreboard: every accepted stop is reported once, in order, with `rsp_cycles==rsp_stop`.
